// File: rtl/irq_priority_ctrl.sv
// ============================================================================
// irq_priority_ctrl
//
// Purpose:
//   Fixed-priority interrupt controller for N sources. Each source is either
//   edge-triggered or level-triggered (chosen per bit by IRQ_EDGE). Pending
//   sources that are enabled by the mask compete for the CPU, and the lowest
//   index wins. A small three-state handshake FSM presents one interrupt at a
//   time:
//     IDLE    -> nothing presented
//     REQ     -> int_req high, int_id frozen until the CPU acks
//     SERVICE -> in_service high until the CPU signals end of interrupt
//   There is no nesting and no preemption. A higher-priority arrival waits
//   until the FSM is back in IDLE.
//
// Parameters:
//   N         number of interrupt sources (power of two, >= 2)
//   IRQ_EDGE  per-source trigger type, 1 = edge, 0 = level
//   IW        width of the encoded interrupt ID
//
// Ports:
//   clk         in   1   clock, all state updates on the rising edge
//   rst_n       in   1   synchronous active-low reset
//   irq_in      in   N   raw interrupt lines
//   mask        in   N   per-source enable (1 = enabled)
//   int_ack     in   1   CPU accepts the presented interrupt
//   eoi         in   1   CPU signals end of service
//   int_req     out  1   interrupt request to the CPU
//   int_id      out  IW  ID of the requested / in-service source
//   pending     out  N   pending register
//   in_service  out  1   high while an interrupt is being serviced
// ============================================================================
module irq_priority_ctrl #(
    parameter int            N        = 32,
    parameter logic [N-1:0]  IRQ_EDGE = '0,
    parameter int            IW       = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  irq_in,
    input  logic [N-1:0]  mask,
    input  logic          int_ack,
    input  logic          eoi,
    output logic          int_req,
    output logic [IW-1:0] int_id,
    output logic [N-1:0]  pending,
    output logic          in_service
);

    localparam int LOGN = $clog2(N);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_irqQ;
    logic [N-1:0]    r_pending;
    logic [IW-1:0]   r_intId;
    logic            r_intReq;
    logic            r_inService;

    logic [N-1:0]    w_edge;
    logic [N-1:0]    w_cand;
    logic [N-1:0]    w_prefix;
    logic [N-1:0]    w_oneHot;
    logic [IW-1:0]   w_winId;
    logic            w_anyCand;
    logic            w_ackTake;
    logic [N-1:0]    w_ackClear;
    logic            w_capturedLive;
    logic [N-1:0]    w_pendingNext;

    // Rising-edge detection against the registered copy of the lines. Because
    // r_irqQ is forced to zero in reset, a line that is already high when
    // reset is released shows exactly one edge, on the first edge after release.
    assign w_edge    = irq_in & ~r_irqQ;

    assign w_cand    = r_pending & mask;
    assign w_anyCand = |w_cand;

    // An ack only counts while a request is actually presented.
    assign w_ackTake = (r_state == REQ) && int_ack;

    // Parallel-prefix OR: after log2(N) doubling steps, bit i holds the OR of
    // candidate bits [i:0]. The first set bit of the prefix is the lowest
    // candidate index, isolated as p & ~(p << 1).
    always_comb begin
        w_prefix = w_cand;
        for (int l = 0; l < LOGN; l++) begin
            w_prefix = w_prefix | (w_prefix << (1 << l));
        end
    end

    assign w_oneHot = w_prefix & ~(w_prefix << 1);

    // One-hot to binary: OR together the indices of the set bit(s). Only one
    // bit can be set, so this is a plain encoder with no priority chain.
    always_comb begin
        w_winId = '0;
        for (int i = 0; i < N; i++) begin
            if (w_oneHot[i]) begin
                w_winId = w_winId | IW'(i);
            end
        end
    end

    // Decode the captured ID: the bit to clear on ack, and whether the
    // captured source is still pending and enabled (needed to decide whether
    // an outstanding request must be withdrawn).
    always_comb begin
        w_ackClear     = '0;
        w_capturedLive = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (r_intId == IW'(i)) begin
                w_ackClear[i]  = w_ackTake;
                w_capturedLive = w_cand[i];
            end
        end
    end

    // Edge sources: a new edge sets the bit and wins over a same-cycle ack
    // clear. Level sources simply follow the line one cycle late and are not
    // affected by ack at all.
    assign w_pendingNext = (IRQ_EDGE & ((r_pending & ~w_ackClear) | w_edge))
                         | (~IRQ_EDGE & irq_in);

    // Input sampling and pending register. Pending latches regardless of the
    // mask; the mask only affects which bits may raise a request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_irqQ    <= '0;
            r_pending <= '0;
        end else begin
            r_irqQ    <= irq_in;
            r_pending <= w_pendingNext;
        end
    end

    // Handshake FSM with registered outputs. The ID is captured only when
    // leaving IDLE and is held through REQ and SERVICE and beyond, so a newer
    // higher-priority candidate never replaces a request already presented.
    // Returning to IDLE takes one edge and a new capture takes another, which
    // guarantees at least one quiet cycle between interrupts (no nesting).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_intId     <= '0;
            r_intReq    <= 1'b0;
            r_inService <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyCand) begin
                        r_state  <= REQ;
                        r_intId  <= w_winId;
                        r_intReq <= 1'b1;
                    end
                end
                REQ: begin
                    // Ack takes precedence; eoi is meaningless here.
                    if (int_ack) begin
                        r_state     <= SERVICE;
                        r_intReq    <= 1'b0;
                        r_inService <= 1'b1;
                    end else if (!w_capturedLive) begin
                        // The source went away (level drop or masked) before
                        // the CPU took it, so the request is withdrawn.
                        r_state  <= IDLE;
                        r_intReq <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        r_state     <= IDLE;
                        r_inService <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_intReq    <= 1'b0;
                    r_inService <= 1'b0;
                end
            endcase
        end
    end

    assign int_req    = r_intReq;
    assign int_id     = r_intId;
    assign pending    = r_pending;
    assign in_service = r_inService;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// ============================================================================
// tb_irq_priority_ctrl
//
// Purpose:
//   Self-checking bench for irq_priority_ctrl with N=8. Two instances share
//   the same stimulus: one with all sources edge-triggered (0xFF) and one
//   with all sources level-triggered (0x00). A behavioural model keeps, per
//   instance, the pending bits, the presented ID and two flags, "request
//   up" and "in service". It picks the winner with a plain lowest-index
//   search. A compare process checks every cycle. Directed scenarios add
//   literal expectations, and a randomized phase follows.
// ============================================================================
module tb_irq_priority_ctrl;

    localparam int N  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rstN;
    logic [N-1:0]  irqIn;
    logic [N-1:0]  maskIn;
    logic          intAck;
    logic          eoi;

    logic          reqE, svcE, reqL, svcL;
    logic [IW-1:0] idE, idL;
    logic [N-1:0]  pendE, pendL;

    int  checkCount = 0;
    int  errorCount = 0;
    bit  compareOn  = 1'b0;

    // Model state, index 0 = edge instance, index 1 = level instance.
    logic [N-1:0]  edgeCfg [2];
    logic [N-1:0]  mLast   [2];
    logic [N-1:0]  mPend   [2];
    int            mId     [2];
    bit            mReq    [2];
    bit            mSvc    [2];

    always #5 clk = ~clk;

    irq_priority_ctrl #(.N(N), .IRQ_EDGE(8'hFF), .IW(IW)) dutEdge (
        .clk        (clk),
        .rst_n      (rstN),
        .irq_in     (irqIn),
        .mask       (maskIn),
        .int_ack    (intAck),
        .eoi        (eoi),
        .int_req    (reqE),
        .int_id     (idE),
        .pending    (pendE),
        .in_service (svcE)
    );

    irq_priority_ctrl #(.N(N), .IRQ_EDGE(8'h00), .IW(IW)) dutLevel (
        .clk        (clk),
        .rst_n      (rstN),
        .irq_in     (irqIn),
        .mask       (maskIn),
        .int_ack    (intAck),
        .eoi        (eoi),
        .int_req    (reqL),
        .int_id     (idL),
        .pending    (pendL),
        .in_service (svcL)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at it.
    task automatic modelStep();
        logic [N-1:0] cand;
        int           first;
        bit           take;
        for (int d = 0; d < 2; d++) begin
            if (!rstN) begin
                mLast[d] = '0;
                mPend[d] = '0;
                mId[d]   = 0;
                mReq[d]  = 1'b0;
                mSvc[d]  = 1'b0;
            end else begin
                cand  = mPend[d] & maskIn;
                first = -1;
                for (int i = N - 1; i >= 0; i--) begin
                    if (cand[i]) first = i;
                end
                take = mReq[d] && intAck;
                for (int i = 0; i < N; i++) begin
                    if (edgeCfg[d][i]) begin
                        if (irqIn[i] && !mLast[d][i]) mPend[d][i] = 1'b1;
                        else if (take && mId[d] == i) mPend[d][i] = 1'b0;
                    end else begin
                        mPend[d][i] = irqIn[i];
                    end
                end
                if (mReq[d]) begin
                    if (intAck) begin
                        mReq[d] = 1'b0;
                        mSvc[d] = 1'b1;
                    end else if (!cand[mId[d]]) begin
                        mReq[d] = 1'b0;
                    end
                end else if (mSvc[d]) begin
                    if (eoi) mSvc[d] = 1'b0;
                end else if (first >= 0) begin
                    mId[d]  = first;
                    mReq[d] = 1'b1;
                end
                mLast[d] = irqIn;
            end
        end
    endtask

    always @(posedge clk) modelStep();

    // Continuous comparison, 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        if (compareOn) begin
            checkOutput("edge int_req",    32'(reqE),  32'(mReq[0]));
            checkOutput("edge in_service", 32'(svcE),  32'(mSvc[0]));
            checkOutput("edge int_id",     32'(idE),   32'(mId[0]));
            checkOutput("edge pending",    32'(pendE), 32'(mPend[0]));
            checkOutput("lvl int_req",     32'(reqL),  32'(mReq[1]));
            checkOutput("lvl in_service",  32'(svcL),  32'(mSvc[1]));
            checkOutput("lvl int_id",      32'(idL),   32'(mId[1]));
            checkOutput("lvl pending",     32'(pendL), 32'(mPend[1]));
        end
    end

    task automatic applyStimulus(input logic rst, input logic [N-1:0] irq,
                                 input logic [N-1:0] msk, input logic ack,
                                 input logic e);
        @(negedge clk);
        rstN   = rst;
        irqIn  = irq;
        maskIn = msk;
        intAck = ack;
        eoi    = e;
    endtask

    // One clock with reset released, then settle past the compare process.
    task automatic cycle(input logic [N-1:0] irq, input logic [N-1:0] msk,
                         input logic ack, input logic e);
        applyStimulus(1'b1, irq, msk, ack, e);
        @(posedge clk);
        #3;
    endtask

    task automatic resetCycle(input logic [N-1:0] irq);
        applyStimulus(1'b0, irq, 8'hFF, 1'b0, 1'b0);
        @(posedge clk);
        #3;
    endtask

    initial begin
        edgeCfg[0] = 8'hFF;
        edgeCfg[1] = 8'h00;
        rstN   = 1'b0;
        irqIn  = '0;
        maskIn = 8'hFF;
        intAck = 1'b0;
        eoi    = 1'b0;
        @(posedge clk);
        #3;
        compareOn = 1'b1;
        resetCycle(8'h00);
        checkOutput("reset int_req",    32'(reqE),  32'd0);
        checkOutput("reset in_service", 32'(svcE),  32'd0);
        checkOutput("reset int_id",     32'(idE),   32'd0);
        checkOutput("reset pending",    32'(pendE), 32'h00);

        // Single edge on source 5: two-cycle latency, ack, eoi.
        cycle(8'h20, 8'hFF, 1'b0, 1'b0);
        checkOutput("lat pending k",  32'(pendE), 32'h20);
        checkOutput("lat req k",      32'(reqE),  32'd0);
        cycle(8'h00, 8'hFF, 1'b0, 1'b0);
        checkOutput("lat req k+1",    32'(reqE),  32'd1);
        checkOutput("lat id k+1",     32'(idE),   32'd5);
        cycle(8'h00, 8'hFF, 1'b1, 1'b0);
        checkOutput("ack in_service", 32'(svcE),  32'd1);
        checkOutput("ack req low",    32'(reqE),  32'd0);
        checkOutput("ack pending",    32'(pendE), 32'h00);
        cycle(8'h00, 8'hFF, 1'b0, 1'b1);
        checkOutput("eoi idle",       32'(svcE),  32'd0);
        checkOutput("eoi id held",    32'(idE),   32'd5);

        // Two simultaneous edges: 3 first, then 5.
        cycle(8'h28, 8'hFF, 1'b0, 1'b0);
        checkOutput("dual pending",   32'(pendE), 32'h28);
        cycle(8'h00, 8'hFF, 1'b0, 1'b0);
        checkOutput("dual first id",  32'(idE),   32'd3);
        checkOutput("dual first req", 32'(reqE),  32'd1);
        cycle(8'h00, 8'hFF, 1'b1, 1'b0);
        checkOutput("dual ack pend",  32'(pendE), 32'h20);
        cycle(8'h00, 8'hFF, 1'b0, 1'b1);
        cycle(8'h00, 8'hFF, 1'b0, 1'b0);
        checkOutput("dual second id", 32'(idE),   32'd5);
        checkOutput("dual second req",32'(reqE),  32'd1);

        // Higher priority source 1 arrives while 5 is presented: no preemption.
        cycle(8'h02, 8'hFF, 1'b0, 1'b0);
        checkOutput("nopre id",       32'(idE),   32'd5);
        checkOutput("nopre pending",  32'(pendE), 32'h22);
        cycle(8'h00, 8'hFF, 1'b0, 1'b0);
        checkOutput("nopre id hold",  32'(idE),   32'd5);
        cycle(8'h00, 8'hFF, 1'b1, 1'b0);
        checkOutput("nopre ack pend", 32'(pendE), 32'h02);
        cycle(8'h00, 8'hFF, 1'b0, 1'b1);
        cycle(8'h00, 8'hFF, 1'b0, 1'b0);
        checkOutput("nopre next id",  32'(idE),   32'd1);
        checkOutput("nopre next req", 32'(reqE),  32'd1);
        cycle(8'h00, 8'hFF, 1'b1, 1'b0);
        cycle(8'h00, 8'hFF, 1'b0, 1'b1);
        checkOutput("nopre drained",  32'(pendE), 32'h00);

        // Masked source still latches; request on the first edge that sees it enabled.
        cycle(8'h01, 8'h00, 1'b0, 1'b0);
        checkOutput("mask pending",   32'(pendE), 32'h01);
        checkOutput("mask no req",    32'(reqE),  32'd0);
        cycle(8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput("mask still no",  32'(reqE),  32'd0);
        cycle(8'h00, 8'h01, 1'b0, 1'b0);
        checkOutput("unmask req",     32'(reqE),  32'd1);
        checkOutput("unmask id",      32'(idE),   32'd0);
        cycle(8'h00, 8'h01, 1'b1, 1'b0);
        cycle(8'h00, 8'hFF, 1'b0, 1'b1);

        // Level source 2 drops while presented: request withdrawn.
        resetCycle(8'h00);
        cycle(8'h04, 8'hFF, 1'b0, 1'b0);
        checkOutput("lvl pending",    32'(pendL), 32'h04);
        cycle(8'h04, 8'hFF, 1'b0, 1'b0);
        checkOutput("lvl req",        32'(reqL),  32'd1);
        checkOutput("lvl id",         32'(idL),   32'd2);
        cycle(8'h00, 8'hFF, 1'b0, 1'b0);
        checkOutput("lvl drop pend",  32'(pendL), 32'h00);
        checkOutput("lvl drop req",   32'(reqL),  32'd1);
        cycle(8'h00, 8'hFF, 1'b0, 1'b0);
        checkOutput("lvl withdrawn",  32'(reqL),  32'd0);
        checkOutput("lvl no service", 32'(svcL),  32'd0);
        cycle(8'h00, 8'hFF, 1'b1, 1'b0);
        cycle(8'h00, 8'hFF, 1'b0, 1'b1);

        // Reset during SERVICE, then source 0 held high across release.
        cycle(8'h10, 8'hFF, 1'b0, 1'b0);
        cycle(8'h00, 8'hFF, 1'b0, 1'b0);
        checkOutput("pre-rst id",     32'(idE),   32'd4);
        cycle(8'h00, 8'hFF, 1'b1, 1'b0);
        checkOutput("pre-rst svc",    32'(svcE),  32'd1);
        resetCycle(8'h01);
        checkOutput("rst req",        32'(reqE),  32'd0);
        checkOutput("rst svc",        32'(svcE),  32'd0);
        checkOutput("rst id",         32'(idE),   32'd0);
        checkOutput("rst pending",    32'(pendE), 32'h00);
        resetCycle(8'h01);
        cycle(8'h01, 8'hFF, 1'b0, 1'b0);
        checkOutput("rel pending",    32'(pendE), 32'h01);
        checkOutput("rel req k",      32'(reqE),  32'd0);
        cycle(8'h01, 8'hFF, 1'b0, 1'b0);
        checkOutput("rel req",        32'(reqE),  32'd1);
        checkOutput("rel id",         32'(idE),   32'd0);
        cycle(8'h01, 8'hFF, 1'b1, 1'b0);
        checkOutput("rel ack pend",   32'(pendE), 32'h00);
        cycle(8'h01, 8'hFF, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cycle(8'h01, 8'hFF, 1'b0, 1'b0);
            checkOutput("rel single",  32'(reqE),  32'd0);
        end

        // Randomized phase with occasional resets and mask changes.
        for (int k = 0; k < 3000; k++) begin
            applyStimulus(($urandom_range(0, 99) != 0),
                          N'($urandom),
                          ($urandom_range(0, 3) == 0) ? N'($urandom) : 8'hFF,
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 2) == 0));
            @(posedge clk);
            #3;
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
